// File: rtl/ctl_to_uart.sv
// Debug-link response path: reads one page of data or program memory and
// streams it to the UART transmitter as "<D|P>[w0,w1,...]\n" in uppercase hex.
module ctl_to_uart #(
  parameter int PBITS = 8,
  parameter int WBITS = 4,
  parameter int ABITS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic             i_reqprog,
  input  logic [PBITS-1:0] i_page,
  output logic             o_memrd,
  output logic             o_memsel,
  output logic [ABITS-1:0] o_memaddr,
  input  logic [31:0]      i_memdata,
  output logic [7:0]       o_charout,
  output logic             o_txstart,
  input  logic             i_txbusy,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_GAP, S_FETCH, S_WAIT, S_LATCH, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    K_HDR, K_OPEN, K_HEX, K_SEP, K_CLOSE, K_NL
  } kind_t;

  localparam logic [WBITS-1:0] LAST_WORD = '1;

  state_t             r_state;
  kind_t              r_kind;
  logic               r_prog;
  logic [PBITS-1:0]   r_page;
  logic [WBITS-1:0]   r_wordidx;
  logic [2:0]         r_nibidx;
  logic [31:0]        r_shift;
  logic               r_memrd;
  logic [ABITS-1:0]   r_memaddr;
  logic [7:0]         r_charout;
  logic               r_txstart;
  logic               r_busy;
  logic               r_done;

  logic [3:0]             w_nib;
  logic [7:0]             w_hexchar;
  logic [7:0]             w_char;
  logic [PBITS+WBITS-1:0] w_fullidx;

  assign w_nib     = r_shift[31:28];
  assign w_hexchar = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
  assign w_fullidx = {r_page, r_wordidx};

  // Byte to emit for whichever packet element the SEND/GAP pair is serving.
  always_comb begin
    w_char = 8'h00;
    unique case (r_kind)
      K_HDR:   w_char = r_prog ? 8'h50 : 8'h44;
      K_OPEN:  w_char = 8'h5B;
      K_HEX:   w_char = w_hexchar;
      K_SEP:   w_char = 8'h2C;
      K_CLOSE: w_char = 8'h5D;
      K_NL:    w_char = 8'h0A;
      default: w_char = 8'h00;
    endcase
  end

  // SEND/GAP is shared by every byte; r_kind selects what follows the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_kind    <= K_HDR;
      r_prog    <= 1'b0;
      r_page    <= '0;
      r_wordidx <= '0;
      r_nibidx  <= '0;
      r_shift   <= '0;
      r_memrd   <= 1'b0;
      r_memaddr <= '0;
      r_charout <= '0;
      r_txstart <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_prog    <= i_reqprog;
            r_page    <= i_page;
            r_wordidx <= '0;
            r_busy    <= 1'b1;
            r_kind    <= K_HDR;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!i_txbusy) begin
            r_charout <= w_char;
            r_txstart <= 1'b1;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          r_txstart <= 1'b0;
          unique case (r_kind)
            K_HDR: begin
              r_kind  <= K_OPEN;
              r_state <= S_SEND;
            end
            K_OPEN: r_state <= S_FETCH;
            K_HEX: begin
              r_shift  <= {r_shift[27:0], 4'h0};
              r_nibidx <= r_nibidx + 3'd1;
              r_state  <= S_SEND;
              if (r_nibidx == 3'd7)
                r_kind <= (r_wordidx == LAST_WORD) ? K_CLOSE : K_SEP;
            end
            K_SEP: begin
              r_wordidx <= r_wordidx + 1'b1;
              r_state   <= S_FETCH;
            end
            K_CLOSE: begin
              r_kind  <= K_NL;
              r_state <= S_SEND;
            end
            K_NL: begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
          endcase
        end
        S_FETCH: begin
          r_memrd   <= 1'b1;
          r_memaddr <= ABITS'(w_fullidx);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_memrd <= 1'b0;
          r_state <= S_LATCH;
        end
        // Memory answers one cycle after the strobe is seen, i.e. now.
        S_LATCH: begin
          r_shift  <= i_memdata;
          r_nibidx <= '0;
          r_kind   <= K_HEX;
          r_state  <= S_SEND;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_memrd   = r_memrd;
  assign o_memsel  = r_prog;
  assign o_memaddr = r_memaddr;
  assign o_charout = r_charout;
  assign o_txstart = r_txstart;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_ctl_to_uart.sv
// Scoreboard bench for ctl_to_uart: a packet-level model queues expected bytes
// and reads; a negedge monitor pops and compares as the DUT strobes them.
module tb_ctl_to_uart;

  localparam int PBITS = 8;
  localparam int WBITS = 4;
  localparam int ABITS = 12;
  localparam int WORDS = 1 << WBITS;

  typedef struct {
    logic [ABITS-1:0] addr;
    logic             sel;
  } rd_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_req;
  logic             i_reqprog;
  logic [PBITS-1:0] i_page;
  logic             o_memrd;
  logic             o_memsel;
  logic [ABITS-1:0] o_memaddr;
  logic [31:0]      i_memdata;
  logic [7:0]       o_charout;
  logic             o_txstart;
  logic             i_txbusy;
  logic             o_busy;
  logic             o_done;

  logic [31:0] memD [1 << ABITS];
  logic [31:0] memP [1 << ABITS];
  logic [7:0]  expByteQ [$];
  rd_t         expRdQ [$];

  int compared   = 0;
  int mismatched = 0;
  int busyLen    = 1;
  int busyLeft   = 0;
  int cycle      = 0;
  int lastStrobe = -1;
  int doneCount  = 0;

  ctl_to_uart #(.PBITS(PBITS), .WBITS(WBITS), .ABITS(ABITS)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_reqprog(i_reqprog), .i_page(i_page),
    .o_memrd(o_memrd), .o_memsel(o_memsel), .o_memaddr(o_memaddr), .i_memdata(i_memdata),
    .o_charout(o_charout), .o_txstart(o_txstart), .i_txbusy(i_txbusy),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // UART model: busy from the cycle after a strobe for busyLen cycles.
  always @(posedge clk) begin
    if (rst) begin
      i_txbusy <= 1'b0;
      busyLeft <= 0;
    end else if (o_txstart) begin
      i_txbusy <= 1'b1;
      busyLeft <= busyLen;
    end else if (busyLeft > 1) begin
      busyLeft <= busyLeft - 1;
    end else begin
      busyLeft <= 0;
      i_txbusy <= 1'b0;
    end
  end

  // Memory model: real data only in the cycle after a read strobe.
  always @(posedge clk) begin
    if (o_memrd) i_memdata <= o_memsel ? memP[o_memaddr] : memD[o_memaddr];
    else         i_memdata <= $urandom;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] hexChar(input int nib);
    return (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
  endfunction

  function automatic void buildExpected(input logic prog, input logic [PBITS-1:0] page);
    logic [31:0] word;
    int addr;
    expByteQ.push_back(prog ? "P" : "D");
    expByteQ.push_back("[");
    for (int w = 0; w < WORDS; w++) begin
      addr = int'(page) * WORDS + w;
      word = prog ? memP[addr] : memD[addr];
      expRdQ.push_back('{addr: ABITS'(addr), sel: prog});
      for (int n = 7; n >= 0; n--) expByteQ.push_back(hexChar(int'((word >> (4 * n)) & 32'hF)));
      if (w < WORDS - 1) expByteQ.push_back(",");
    end
    expByteQ.push_back("]");
    expByteQ.push_back(8'h0A);
  endfunction

  // Monitor: every strobe the DUT presents is checked against the queues.
  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      if (o_txstart) begin
        checkOutput("txbusyAtStrobe", {31'd0, i_txbusy}, 32'd0);
        if (lastStrobe >= 0) checkOutput("strobeGapOk", {31'd0, (cycle - lastStrobe) >= 2}, 32'd1);
        lastStrobe = cycle;
        if (expByteQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedByte: got 0x%0h, want no byte", o_charout);
        end else begin
          checkOutput("charout", {24'd0, o_charout}, {24'd0, expByteQ.pop_front()});
        end
      end
      if (o_memrd) begin
        if (expRdQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedRead: got addr 0x%0h, want no read", o_memaddr);
        end else begin
          rd_t e;
          e = expRdQ.pop_front();
          checkOutput("memaddr", {20'd0, o_memaddr}, {20'd0, e.addr});
          checkOutput("memsel", {31'd0, o_memsel}, {31'd0, e.sel});
        end
      end
      if (o_done) doneCount++;
    end
  end

  task automatic applyStimulus(input logic prog, input logic [PBITS-1:0] page);
    i_reqprog = prog;
    i_page    = page;
    i_req     = 1'b1;
    buildExpected(prog, page);
    @(negedge clk);
    i_req     = 1'b0;
    i_reqprog = 1'($urandom);
    i_page    = PBITS'($urandom);
    checkOutput("busyAfterReq", {31'd0, o_busy}, 32'd1);
  endtask

  // Returns 1 ns into the done cycle.
  task automatic waitDone(input int budget);
    int start;
    start = doneCount;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_done) break;
    end
    #1;
    checkOutput("doneSeen", {31'd0, o_done}, 32'd1);
    checkOutput("donePulses", 32'(doneCount - start), 32'd1);
    checkOutput("bytesLeft", 32'(expByteQ.size()), 32'd0);
    checkOutput("readsLeft", 32'(expRdQ.size()), 32'd0);
    checkOutput("busyInDone", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic runPacket(input logic prog, input logic [PBITS-1:0] page);
    applyStimulus(prog, page);
    waitDone(200 * (busyLen + 4));
    @(negedge clk);
    checkOutput("busyFall", {31'd0, o_busy}, 32'd0);
    checkOutput("doneFall", {31'd0, o_done}, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".memrd"}, {31'd0, o_memrd}, 32'd0);
    checkOutput({tag, ".memsel"}, {31'd0, o_memsel}, 32'd0);
    checkOutput({tag, ".memaddr"}, {20'd0, o_memaddr}, 32'd0);
    checkOutput({tag, ".charout"}, {24'd0, o_charout}, 32'd0);
    checkOutput({tag, ".txstart"}, {31'd0, o_txstart}, 32'd0);
    checkOutput({tag, ".busy"}, {31'd0, o_busy}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       prog;
    logic [7:0] page;
    int         seen;

    for (int a = 0; a < (1 << ABITS); a++) begin
      memD[a] = $urandom;
      memP[a] = $urandom;
    end
    memD[12'h030] = 32'h12345678;
    memD[12'h031] = 32'h00000000;
    memD[12'h032] = 32'hDEADBEEF;
    memD[12'h033] = 32'hFFFFFFFF;

    rst = 1'b1;
    i_req = 1'b0;
    i_reqprog = 1'b0;
    i_page = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] data page 3, known words");
    busyLen = 1;
    runPacket(1'b0, 8'h03);

    $display("[TB] program page 0xFF");
    busyLen = 3;
    runPacket(1'b1, 8'hFF);

    $display("[TB] slow UART, 20 busy cycles per byte");
    busyLen = 20;
    runPacket(1'($urandom), 8'($urandom));

    $display("[TB] requests mid-packet and in the done cycle are ignored");
    busyLen = 2;
    prog = 1'b0;
    page = 8'h5A;
    applyStimulus(prog, page);
    repeat (100) @(negedge clk);
    i_req = 1'b1; i_reqprog = ~prog; i_page = page ^ 8'h33;
    @(negedge clk);
    i_req = 1'b0;
    waitDone(200 * (busyLen + 4));
    i_req = 1'b1; i_reqprog = 1'b1; i_page = 8'h77;
    @(negedge clk);
    i_req = 1'b0;
    checkOutput("busyLowAfterDone", {31'd0, o_busy}, 32'd0);
    applyStimulus(1'b1, 8'hA5);
    waitDone(200 * (busyLen + 4));
    @(negedge clk);
    checkOutput("busyFall2", {31'd0, o_busy}, 32'd0);

    $display("[TB] reset during the 10th byte");
    applyStimulus(1'b0, 8'($urandom));
    seen = 0;
    for (int n = 0; n < 2000 && seen < 10; n++) begin
      @(negedge clk);
      if (o_txstart) seen++;
    end
    checkOutput("reached10thByte", 32'(seen), 32'd10);
    #1 rst = 1'b1;
    #1 checkResetOutputs("midReset");
    expByteQ.delete();
    expRdQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("idleAfterReset", {31'd0, o_busy}, 32'd0);
    runPacket(1'b1, 8'($urandom));

    $display("[TB] random packets");
    for (int k = 0; k < 4; k++) begin
      busyLen = int'($urandom_range(1, 5));
      runPacket(1'($urandom), 8'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ctl_to_uart.md
Name: ctl_to_uart

Overview:
- Response path of the UART debug link: the transmit-side counterpart of the command parser that decodes H/Z/S/R/P/V packets.
- On request, reads one page of data or program memory and streams it as an ASCII packet to the UART transmitter, one byte at a time.
- Packet format: `<hdr>[<w0>,<w1>,...,<wN-1>]\n`
  - hdr = 'D' for data memory, 'P' for program memory.
  - Each word is 8 uppercase hex digits, MSB nibble first.
- Sits between the memory debug read ports and the UART TX byte interface.

Parameters:
- PBITS, 8, page index width (matches the view-page width).
- WBITS, 4, log2 of words per page (default 16 words).
- ABITS, 12, memory read address width; ABITS >= PBITS+WBITS.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  single-cycle dump request; sampled only in IDLE.
- reqprog  in  1  1 = program memory, 0 = data memory; latched with req.
- page  in  PBITS  page index; latched with req.
- memrd  out  1  single-cycle read strobe.
- memsel  out  1  memory select (1 = prog), equal to the latched reqprog.
- memaddr  out  ABITS  word address = {page, wordidx}, zero-extended to ABITS.
- memdata  in  32  read data, valid exactly 1 cycle after memrd.
- charout  out  8  byte to transmit, valid while txstart=1.
- txstart  out  1  single-cycle transmit strobe.
- txbusy  in  1  UART TX busy; rises the cycle after txstart, falls when the byte is done.
- busy  out  1  high from the cycle after an accepted req until the done cycle inclusive.
- done  out  1  single-cycle pulse when the packet is complete.

Behaviour:
- Reset values: memrd=0, memsel=0, memaddr=0, charout=0, txstart=0, busy=0, done=0, state=IDLE, wordidx=0, nibidx=0.
- Reset is asynchronous and is honoured mid-packet: the transfer is abandoned immediately and the partial packet is not completed.
- Byte emission primitive EMIT(c), all bytes going through it:
  - State SEND: wait while txbusy=1. When txbusy=0, drive charout=c and txstart=1 for exactly one cycle.
  - Then one mandatory GAP cycle, in which txbusy is not sampled.
  - Then continue to the next state.
  - At most one txstart per 2 cycles; no txstart while txbusy=1.
- State sequence:
  - IDLE: on req=1, latch reqprog and page, set wordidx=0, busy=1, go to HDR. req in any other state is ignored, not queued.
  - HDR: EMIT('P' if prog else 'D'), go to OPEN.
  - OPEN: EMIT('['), go to FETCH.
  - FETCH: memaddr={page,wordidx}, memrd=1 for one cycle, go to LATCH.
  - LATCH: capture memdata into a 32-bit shift register, nibidx=0, go to HEX.
  - HEX: EMIT of the top nibble as ASCII ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then shift left by 4 and increment nibidx. After the 8th nibble:
    - if wordidx = 2^WBITS-1, go to CLOSE;
    - otherwise go to SEP.
  - SEP: EMIT(','), wordidx+1, go to FETCH.
  - CLOSE: EMIT(']'), go to NL.
  - NL: EMIT(0x0A). In the GAP cycle after its txstart, done=1 for one cycle (busy still 1). Next cycle: busy=0, state=IDLE.
- Packet length is 3 + 2^WBITS*9 bytes; 147 bytes at defaults.
- Memory is read exactly once per word, in ascending address order.
- Arithmetic:
  - wordidx is WBITS wide and never wraps within a packet.
  - memaddr upper bits above PBITS+WBITS are 0.
  - page = 2^PBITS-1 is legal; there is no carry into other pages.
- memsel holds the latched reqprog from the accepting cycle until the next accepted req.
- Simultaneous events:
  - req in the done cycle is ignored.
  - req in the first IDLE cycle after done is accepted.
- txbusy stuck at 1: the block waits indefinitely in SEND. There is no timeout.

Test Plan:
- WBITS=2, data page 3, words 0x12345678, 0x00000000, 0xDEADBEEF, 0xFFFFFFFF -> exact byte stream "D[12345678,00000000,DEADBEEF,FFFFFFFF]\n" (39 bytes); memaddr sequence 0x00C, 0x00D, 0x00E, 0x00F; memsel=0; one done pulse.
- reqprog=1, page 0xFF, defaults -> header 'P'; memaddr 0xFF0..0xFFF; memsel=1; 147 bytes ending "]\n".
- Model holds txbusy=1 for 20 cycles after each txstart -> no txstart while txbusy=1; stream content identical to the fast case; gap of at least 2 cycles between strobes.
- Second req pulses mid-packet and in the done cycle -> ignored, exactly one packet; req one cycle after busy falls -> new packet starts with its header.
- Assert rst during the 10th byte -> all outputs at reset values in the same cycle; no further txstart; a new req after rst release yields a full, correct packet.
- memdata driven with garbage except in the cycle after memrd -> hex output reflects only the post-memrd values; exactly 2^WBITS memrd pulses per packet.
